// File: rtl/video_pkg.sv
// Shared video defaults, colour-bar palette and the stream master FSM encoding.
package video_pkg;

    localparam int H_ACTIVE_DEF = 1024;
    localparam int V_ACTIVE_DEF = 768;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        c = BAR_BLACK;
        unique case (idx)
            3'd0: c = BAR_WHITE;
            3'd1: c = BAR_YELLOW;
            3'd2: c = BAR_CYAN;
            3'd3: c = BAR_GREEN;
            3'd4: c = BAR_MAGENTA;
            3'd5: c = BAR_RED;
            3'd6: c = BAR_BLUE;
            3'd7: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with registered write and first-word-fall-through read.
module pixel_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axis_pixel_master.sv
// Frame-aware AXI4-Stream pixel master fed by a FIFO or a colour-bar generator.
module axis_pixel_master
    import video_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        M_AXIS_ACLK,
    input  logic        M_AXIS_ARESETN,
    input  logic        enable,
    input  logic        pattern_en,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [23:0] M_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    output logic        M_AXIS_TLAST,
    output logic        M_AXIS_TUSER,
    input  logic        M_AXIS_TREADY,
    output logic        frame_done,
    output logic        underrun
);

    localparam logic [10:0] X_LAST   = 11'(H_ACTIVE - 1);
    localparam logic [10:0] Y_LAST   = 11'(V_ACTIVE - 1);
    localparam logic [10:0] BAR_LAST = 11'(H_ACTIVE / 8 - 1);

    state_t      state;
    state_t      state_nxt;
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] bar_cnt;
    logic [2:0]  bar_idx;
    logic        src_pat;
    logic        out_eof;
    logic [23:0] fifo_data;
    logic        fifo_full;
    logic        fifo_empty;
    logic        at_origin;
    logic        cur_pat;
    logic        active;
    logic        slot;
    logic        load;
    logic        fifo_rd;
    logic        eof_pending;

    pixel_fifo #(
        .WIDTH(24),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (M_AXIS_ACLK),
        .rst_n  (M_AXIS_ARESETN),
        .wr_en  (pix_valid),
        .wr_data(pix_data),
        .rd_en  (fifo_rd),
        .rd_data(fifo_data),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign pix_ready = !fifo_full;
    assign at_origin = (x == '0) && (y == '0);
    assign cur_pat   = at_origin ? pattern_en : src_pat;

    // Counters back at the origin while stopping means the frame is fully loaded.
    assign active = (state == ST_RUN) ||
                    (state == ST_STOPPING && !at_origin);
    assign slot        = active && (!M_AXIS_TVALID || M_AXIS_TREADY);
    assign load        = slot && (cur_pat || !fifo_empty);
    assign fifo_rd     = load && !cur_pat;
    assign eof_pending = M_AXIS_TVALID && out_eof && !M_AXIS_TREADY;

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) state <= ST_IDLE;
        else                 state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (enable && at_origin) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) state_nxt = ST_STOPPING;
            end
            ST_STOPPING: begin
                if (enable)
                    state_nxt = ST_RUN;
                else if (at_origin && !eof_pending)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            x             <= '0;
            y             <= '0;
            bar_cnt       <= '0;
            bar_idx       <= '0;
            src_pat       <= 1'b0;
            out_eof       <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TUSER  <= 1'b0;
            frame_done    <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            frame_done <= M_AXIS_TVALID && M_AXIS_TREADY && out_eof;

            if (state == ST_IDLE && state_nxt == ST_RUN)
                underrun <= 1'b0;
            else if (slot && !cur_pat && fifo_empty)
                underrun <= 1'b1;

            if (load) begin
                M_AXIS_TVALID <= 1'b1;
                M_AXIS_TDATA  <= cur_pat ? bar_color(bar_idx) : fifo_data;
                M_AXIS_TLAST  <= (x == X_LAST);
                M_AXIS_TUSER  <= at_origin;
                out_eof       <= (x == X_LAST) && (y == Y_LAST);
                if (at_origin) src_pat <= pattern_en;
                if (x == X_LAST) begin
                    x       <= '0;
                    bar_cnt <= '0;
                    bar_idx <= '0;
                    y       <= (y == Y_LAST) ? '0 : y + 11'd1;
                end else begin
                    x <= x + 11'd1;
                    if (bar_cnt == BAR_LAST) begin
                        bar_cnt <= '0;
                        bar_idx <= bar_idx + 3'd1;
                    end else begin
                        bar_cnt <= bar_cnt + 11'd1;
                    end
                end
            end else if (M_AXIS_TREADY) begin
                M_AXIS_TVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_pixel_master.sv
// Scoreboard bench: FIFO and pattern frames, backpressure, underrun,
// frame-boundary stop and mid-frame reset against a frame-level model.
module tb_axis_pixel_master;

    localparam int H     = 8;
    localparam int V     = 2;
    localparam int D     = 4;
    localparam int FRAME = H * V;
    localparam logic [23:0] BARS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        enable     = 1'b0;
    logic        pattern_en = 1'b0;
    logic [23:0] pix_data   = '0;
    logic        pix_valid  = 1'b0;
    logic        pix_ready;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tuser;
    logic        tready     = 1'b0;
    logic        frame_done;
    logic        underrun;

    int n_checks  = 0;
    int n_fail    = 0;
    int beats     = 0;
    int frames    = 0;
    int n_written = 0;
    int k         = 0;
    int gap_pct   = 0;
    int rdy_mode  = 0;

    bit          cur_pat    = 1'b0;
    bit          stall_prev = 1'b0;
    bit          eof_prev   = 1'b0;
    logic [25:0] held       = '0;

    logic [23:0] wr_q[$];
    logic [23:0] fifo_model[$];
    bit          frame_q[$];

    axis_pixel_master #(
        .H_ACTIVE  (H),
        .V_ACTIVE  (V),
        .FIFO_DEPTH(D)
    ) dut (
        .M_AXIS_ACLK   (clk),
        .M_AXIS_ARESETN(rst_n),
        .enable        (enable),
        .pattern_en    (pattern_en),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .M_AXIS_TDATA  (tdata),
        .M_AXIS_TVALID (tvalid),
        .M_AXIS_TLAST  (tlast),
        .M_AXIS_TUSER  (tuser),
        .M_AXIS_TREADY (tready),
        .frame_done    (frame_done),
        .underrun      (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tvalid, tlast, tuser} == 3'b000, {tag, "_flags"},
              {tvalid, tlast, tuser}, 0);
        check(tdata == 24'h0, {tag, "_tdata"}, tdata, 0);
        check(pix_ready == 1'b1, {tag, "_pix_ready"}, pix_ready, 1);
        check(frame_done == 1'b0, {tag, "_frame_done"}, frame_done, 0);
        check(underrun == 1'b0, {tag, "_underrun"}, underrun, 0);
    endtask

    task automatic wait_beats(input int target, input int budget, input string what);
        int n = 0;
        while (beats < target && n < budget) begin
            step(1);
            n++;
        end
        check(beats >= target, what, beats, target);
    endtask

    task automatic wait_frames(input int target, input int budget, input string what);
        int n = 0;
        while (frames < target && n < budget) begin
            step(1);
            n++;
        end
        check(frames >= target, what, frames, target);
    endtask

    task automatic run_frame(input bit pat, input int stop_after, input bit fill);
        int b = beats;
        int f = frames;
        if (fill && !pat)
            for (int i = 0; i < FRAME; i++) wr_q.push_back(24'($urandom));
        frame_q.push_back(pat);
        pattern_en = pat;
        enable = 1'b1;
        wait_beats(b + stop_after, 400, "frame_start");
        enable = 1'b0;
        pattern_en = 1'($urandom);
        wait_frames(f + 1, 800, "frame_end");
        step(3);
    endtask

    task automatic beat_check();
        logic [23:0] exp_d;
        int x;
        exp_d = 24'h0;
        if (k == 0) begin
            check(frame_q.size() != 0, "frame_expected", tdata, 0);
            cur_pat = (frame_q.size() != 0) ? frame_q.pop_front() : 1'b0;
        end
        x = k % H;
        if (cur_pat) begin
            exp_d = BARS[x / (H / 8)];
        end else begin
            check(fifo_model.size() != 0, "pixel_available", tdata, 0);
            if (fifo_model.size() != 0) exp_d = fifo_model.pop_front();
        end
        check({tdata, tlast, tuser} == {exp_d, x == H - 1, k == 0}, "beat",
              {tdata, tlast, tuser}, {exp_d, x == H - 1, k == 0});
        eof_prev = (k == FRAME - 1);
        k = (k + 1) % FRAME;
        beats++;
    endtask

    // Output monitor and scoreboard.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            k = 0;
            stall_prev = 1'b0;
            eof_prev = 1'b0;
            fifo_model.delete();
            frame_q.delete();
        end else begin
            if (stall_prev)
                check(tvalid && ({tdata, tlast, tuser} == held), "hold_stable",
                      {tvalid, tdata, tlast, tuser}, {1'b1, held});
            if (frame_done || eof_prev)
                check(frame_done == eof_prev, "frame_done_pulse", frame_done, eof_prev);
            if (frame_done) frames++;
            eof_prev = 1'b0;
            if (tvalid && tready) beat_check();
            stall_prev = tvalid && !tready;
            held = {tdata, tlast, tuser};
        end
    end

    // Pixel writer and TREADY driver.
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 0)      tready = 1'b1;
        else if (rdy_mode == 1) tready = 1'($urandom_range(0, 1));
        else                    tready = 1'b0;
        if (rst_n && wr_q.size() > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
            pix_valid = 1'b1;
            pix_data = wr_q[0];
            if (pix_ready) begin
                fifo_model.push_back(wr_q.pop_front());
                n_written++;
            end
        end else begin
            pix_valid = 1'b0;
        end
    end

    initial begin
        int b;
        int f;
        int w;
        logic [25:0] cap;

        step(3);
        check_reset("reset");
        rst_n = 1'b1;
        step(2);

        // Directed FIFO frame, enable dropped at (2,0).
        rdy_mode = 0;
        gap_pct = 0;
        for (int i = 1; i <= FRAME; i++) wr_q.push_back(24'(i));
        run_frame(1'b0, 3, 1'b0);
        step(10);
        check(tvalid == 1'b0, "idle_after_stop", tvalid, 0);
        check(frames == 1, "frame_count_1", frames, 1);

        // Prefill to full in IDLE, then a mid-line stall.
        b = beats;
        f = frames;
        w = n_written;
        for (int i = 0; i < FRAME; i++) wr_q.push_back(24'h100000 + 24'(i));
        frame_q.push_back(1'b0);
        pattern_en = 1'b0;
        step(10);
        check(pix_ready == 1'b0, "full_ready", pix_ready, 0);
        check(n_written - w == D, "full_count", n_written - w, D);
        enable = 1'b1;
        wait_beats(b + 3, 100, "stall_start");
        rdy_mode = 2;
        step(2);
        cap = {tdata, tlast, tuser};
        step(5);
        check(tvalid && ({tdata, tlast, tuser} == cap), "stall_hold",
              {tvalid, tdata, tlast, tuser}, {1'b1, cap});
        rdy_mode = 0;
        enable = 1'b0;
        wait_frames(f + 1, 200, "stall_frame_end");
        step(3);

        // Pattern frame with 3 pixels parked in the FIFO.
        for (int i = 0; i < 3; i++) wr_q.push_back(24'h200000 + 24'(i));
        step(8);
        run_frame(1'b1, 1, 1'b0);
        check(pix_ready == 1'b1, "pattern_ready", pix_ready, 1);

        // Underrun after the 3 parked pixels, then resume.
        b = beats;
        f = frames;
        pattern_en = 1'b0;
        frame_q.push_back(1'b0);
        enable = 1'b1;
        step(15);
        check(beats - b == 3, "underrun_beats", beats - b, 3);
        check(tvalid == 1'b0, "underrun_tvalid", tvalid, 0);
        check(underrun == 1'b1, "underrun_flag", underrun, 1);
        for (int i = 0; i < FRAME - 3; i++) wr_q.push_back(24'h300000 + 24'(i));
        enable = 1'b0;
        wait_frames(f + 1, 200, "underrun_frame_end");
        step(3);
        check(underrun == 1'b1, "underrun_sticky", underrun, 1);

        // Randomised frames with random gaps and backpressure.
        rdy_mode = 1;
        gap_pct = 30;
        for (int i = 0; i < 5; i++) begin
            run_frame((i == 0) ? 1'b1 : 1'($urandom_range(0, 1)),
                      int'($urandom_range(1, FRAME - 2)), 1'b1);
            if (i == 0) check(underrun == 1'b0, "underrun_cleared", underrun, 0);
        end

        // Mid-frame reset.
        rdy_mode = 0;
        gap_pct = 0;
        pattern_en = 1'b0;
        b = beats;
        for (int i = 0; i < FRAME; i++) wr_q.push_back(24'($urandom));
        frame_q.push_back(1'b0);
        enable = 1'b1;
        wait_beats(b + 13, 200, "reset_point");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        check_reset("midframe");
        wr_q.delete();
        step(2);
        rst_n = 1'b1;
        step(2);
        run_frame(1'b0, 2, 1'b1);

        check(frames == 10, "frame_total", frames, 10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
